// File: rtl/word_uart_serializer.sv
// Word-to-UART serializer: a DEPTH-word FIFO feeding a configurable UART framer
// that emits WORD_SIZE/BYTE_SIZE frames per word on a single idle-high line.
module word_uart_serializer #(
  parameter int WORD_SIZE    = 32,
  parameter int BYTE_SIZE    = 8,
  parameter int DEPTH        = 64,
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int MSB_FIRST    = 0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [WORD_SIZE-1:0]       data_in,
  input  logic                       valid_in,
  output logic                       sig,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       busy,
  output logic                       overflow
);
  localparam int N         = WORD_SIZE / BYTE_SIZE;
  localparam int PTR_W     = $clog2(DEPTH);
  localparam int LEVEL_W   = $clog2(DEPTH + 1);
  localparam int BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam int BIT_W     = $clog2(BYTE_SIZE);
  localparam int BYTE_W    = (N > 1) ? $clog2(N) : 1;
  localparam int FIRST_LSB = (MSB_FIRST != 0) ? (WORD_SIZE - BYTE_SIZE) : 0;

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

  // ---------------------------------------------------------------- FIFO
  logic [WORD_SIZE-1:0] mem [DEPTH];
  logic [WORD_SIZE-1:0] rd_word_reg;
  logic [PTR_W-1:0]     wr_ptr_reg, rd_ptr_reg;
  logic [LEVEL_W-1:0]   level_reg, level_next;
  logic                 full_reg, empty_reg, overflow_reg;
  logic                 push, pop;

  assign push = valid_in && !full_reg;

  // Storage has no reset so it maps onto block RAM; the word is read on the pop edge.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr_reg] <= data_in;
    if (pop)  rd_word_reg <= mem[rd_ptr_reg];
  end

  always_comb begin
    level_next = level_reg;
    case ({push, pop})
      2'b10:   level_next = level_reg + LEVEL_W'(1);
      2'b01:   level_next = level_reg - LEVEL_W'(1);
      default: level_next = level_reg;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      full_reg     <= 1'b0;
      empty_reg    <= 1'b1;
      overflow_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      level_reg <= level_next;
      full_reg  <= (level_next == LEVEL_W'(DEPTH));
      empty_reg <= (level_next == '0);
      if (valid_in && full_reg) overflow_reg <= 1'b1;
    end
  end

  // ---------------------------------------------------------------- framer
  state_t               state_reg, state_next;
  logic [BAUD_W-1:0]    baud_reg, baud_next;
  logic [BIT_W-1:0]     bit_reg, bit_next;
  logic [BYTE_W-1:0]    byte_cnt_reg, byte_cnt_next;
  logic [BYTE_SIZE-1:0] byte_reg, byte_next;
  logic [WORD_SIZE-1:0] word_reg, word_next;
  logic                 parity_reg, parity_next;
  logic                 sig_reg, sig_next;
  logic                 baud_tc;
  logic [WORD_SIZE-1:0] src_word, rest_word;
  logic [BYTE_SIZE-1:0] first_byte;

  // The first byte of a word comes straight from the FIFO read register; later
  // bytes come from the remainder kept in word_reg.
  assign src_word   = (byte_cnt_reg == '0) ? rd_word_reg : word_reg;
  assign first_byte = src_word[FIRST_LSB +: BYTE_SIZE];
  assign rest_word  = (MSB_FIRST != 0) ? (src_word << BYTE_SIZE) : (src_word >> BYTE_SIZE);
  assign baud_tc    = (baud_reg == BAUD_W'(CLKS_PER_BIT - 1));

  always_comb begin
    state_next    = state_reg;
    baud_next     = (state_reg == ST_IDLE || baud_tc) ? '0 : baud_reg + BAUD_W'(1);
    bit_next      = bit_reg;
    byte_cnt_next = byte_cnt_reg;
    byte_next     = byte_reg;
    word_next     = word_reg;
    parity_next   = parity_reg;
    pop           = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!empty_reg) begin
          pop           = 1'b1;
          byte_cnt_next = '0;
          state_next    = ST_START;
        end
      end
      ST_START: begin
        if (baud_tc) begin
          byte_next   = first_byte;
          word_next   = rest_word;
          parity_next = (PARITY == 2) ? ~(^first_byte) : ^first_byte;
          bit_next    = '0;
          state_next  = ST_DATA;
        end
      end
      ST_DATA: begin
        if (baud_tc) begin
          byte_next = byte_reg >> 1;
          if (bit_reg == BIT_W'(BYTE_SIZE - 1)) begin
            bit_next   = '0;
            state_next = (PARITY != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_next = bit_reg + BIT_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (baud_tc) begin
          bit_next   = '0;
          state_next = ST_STOP;
        end
      end
      ST_STOP: begin
        if (baud_tc) begin
          if (bit_reg == BIT_W'(STOP_BITS - 1)) begin
            bit_next = '0;
            if (byte_cnt_reg != BYTE_W'(N - 1)) begin
              byte_cnt_next = byte_cnt_reg + BYTE_W'(1);
              state_next    = ST_START;
            end else if (!empty_reg) begin
              // Chain the next word with no idle bit in between.
              pop           = 1'b1;
              byte_cnt_next = '0;
              state_next    = ST_START;
            end else begin
              state_next = ST_IDLE;
            end
          end else begin
            bit_next = bit_reg + BIT_W'(1);
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // The line is driven from a register, so decode the level for the next state.
    case (state_next)
      ST_START:  sig_next = 1'b0;
      ST_DATA:   sig_next = byte_next[0];
      ST_PARITY: sig_next = parity_next;
      default:   sig_next = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      baud_reg     <= '0;
      bit_reg      <= '0;
      byte_cnt_reg <= '0;
      byte_reg     <= '0;
      word_reg     <= '0;
      parity_reg   <= 1'b0;
      sig_reg      <= 1'b1;
    end else begin
      state_reg    <= state_next;
      baud_reg     <= baud_next;
      bit_reg      <= bit_next;
      byte_cnt_reg <= byte_cnt_next;
      byte_reg     <= byte_next;
      word_reg     <= word_next;
      parity_reg   <= parity_next;
      sig_reg      <= sig_next;
    end
  end

  assign sig      = sig_reg;
  assign full     = full_reg;
  assign empty    = empty_reg;
  assign level    = level_reg;
  assign busy     = (state_reg != ST_IDLE);
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_word_uart_serializer.sv
// Six serializer configurations run in lockstep; expected bytes are queued when a
// word is accepted and per-instance line decoders pop and compare each frame.
module tb_word_uart_serializer;
  localparam int NCFG = 6;
  localparam int CPB  = 4;
  localparam int C_MSB   [NCFG] = '{0, 1, 0, 0, 0, 0};
  localparam int C_PAR   [NCFG] = '{0, 0, 1, 2, 0, 0};
  localparam int C_STOP  [NCFG] = '{1, 1, 1, 1, 2, 1};
  localparam int C_DEPTH [NCFG] = '{8, 8, 8, 8, 8, 4};

  typedef struct packed {
    logic [7:0] data;
    logic       chained;
  } exp_t;

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic [31:0]          data_in = '0;
  logic                 valid_in = 1'b0;
  logic [NCFG-1:0]      drop_mask = '0;
  logic                 chained = 1'b0;
  logic                 check_q = 1'b0;
  logic [NCFG-1:0]      sig_w, full_w, empty_w, busy_w, ovf_w;
  logic [NCFG-1:0][7:0] level_w;
  int                   vectors = 0;
  int                   miscompares = 0;
  int                   cyc = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int frame_len(input int c);
    return (1 + 8 + ((C_PAR[c] != 0) ? 1 : 0) + C_STOP[c]) * CPB;
  endfunction

  task automatic check(input string name, input int c, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s cfg%0d: got %0h, expected %0h", name, c, act, exp);
    end
  endtask

  for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
    localparam int LW = $clog2(C_DEPTH[gi] + 1);
    localparam int F  = (1 + 8 + ((C_PAR[gi] != 0) ? 1 : 0) + C_STOP[gi]) * CPB;
    localparam int NB = F / CPB;
    logic [LW-1:0] level_loc;
    exp_t          exp_q [$];

    word_uart_serializer #(
      .WORD_SIZE(32), .BYTE_SIZE(8), .DEPTH(C_DEPTH[gi]), .CLKS_PER_BIT(CPB),
      .PARITY(C_PAR[gi]), .STOP_BITS(C_STOP[gi]), .MSB_FIRST(C_MSB[gi])
    ) dut (
      .clock(clock), .reset(reset), .data_in(data_in), .valid_in(valid_in),
      .sig(sig_w[gi]), .full(full_w[gi]), .empty(empty_w[gi]), .level(level_loc),
      .busy(busy_w[gi]), .overflow(ovf_w[gi])
    );
    assign level_w[gi] = 8'(level_loc);

    always @(posedge clock) begin : sb_push
      exp_t e;
      int   idx;
      if (reset) begin
        exp_q.delete();
      end else if (valid_in && !drop_mask[gi]) begin
        for (int n = 0; n < 4; n++) begin
          idx       = (C_MSB[gi] != 0) ? 3 - n : n;
          e.data    = data_in[idx*8 +: 8];
          e.chained = (n != 0) || chained;
          exp_q.push_back(e);
        end
      end
    end

    initial begin : mon
      logic [15:0] bits, exp_bits;
      logic        glitch, aborted;
      int          start_cyc, last_start, pos;
      exp_t        e;
      last_start = -100000;
      forever begin
        @(negedge clock);
        if (!reset && sig_w[gi] === 1'b0) begin
          start_cyc = cyc;
          glitch    = 1'b0;
          aborted   = 1'b0;
          bits      = '0;
          for (int b = 0; b < NB && !aborted; b++) begin
            for (int k = 0; k < CPB && !aborted; k++) begin
              if (b != 0 || k != 0) @(negedge clock);
              if (reset) aborted = 1'b1;
              else if (k == 0) bits[b] = sig_w[gi];
              else if (sig_w[gi] !== bits[b]) glitch = 1'b1;
            end
          end
          if (!aborted) begin
            if (exp_q.size() == 0) begin
              vectors++;
              miscompares++;
              $display("FAIL unexpected frame cfg%0d: got frame %0h, expected no frame", gi, bits);
            end else begin
              e        = exp_q.pop_front();
              exp_bits = '0;
              exp_bits[8:1] = e.data;
              pos = 9;
              if (C_PAR[gi] != 0) begin
                exp_bits[9] = (C_PAR[gi] == 2) ? ~(^e.data) : ^e.data;
                pos = 10;
              end
              for (int s = 0; s < C_STOP[gi]; s++) exp_bits[pos + s] = 1'b1;
              check("frame bits", gi, bits, exp_bits);
              check("bit period", gi, glitch, 0);
              if (e.chained) check("frame spacing", gi, start_cyc - last_start, F);
            end
            last_start = start_cyc;
          end
        end
      end
    end

    initial begin : fin
      wait (check_q);
      check("leftover bytes", gi, exp_q.size(), 0);
    end
  end

  task automatic wait_idle(input int bound);
    int t;
    t = 0;
    @(negedge clock);
    while (!(busy_w == '0 && empty_w == '1) && t < bound) begin
      @(negedge clock);
      t++;
    end
    if (!(busy_w == '0 && empty_w == '1)) begin
      vectors++;
      miscompares++;
      $display("FAIL idle timeout: got busy=%b empty=%b, expected all idle", busy_w, empty_w);
    end
  endtask

  task automatic single_word(input logic [31:0] w);
    int first_zero [NCFG];
    @(posedge clock); #1;
    data_in = w; valid_in = 1'b1; chained = 1'b0; drop_mask = '0;
    @(posedge clock); #1;
    valid_in = 1'b0;
    @(negedge clock);
    for (int c = 0; c < NCFG; c++) begin
      check("empty after push", c, empty_w[c], 0);
      check("level after push", c, level_w[c], 1);
      check("sig before pop", c, sig_w[c], 1);
    end
    @(negedge clock);
    for (int c = 0; c < NCFG; c++) begin
      check("start bit latency", c, sig_w[c], 0);
      check("busy at start", c, busy_w[c], 1);
      check("level after pop", c, level_w[c], 0);
      first_zero[c] = 0;
    end
    for (int m = 2; m <= 260; m++) begin
      @(negedge clock);
      for (int c = 0; c < NCFG; c++)
        if (first_zero[c] == 0 && !busy_w[c]) first_zero[c] = m;
    end
    for (int c = 0; c < NCFG; c++) begin
      check("busy cycles", c, first_zero[c] - 1, 4 * frame_len(c));
      check("idle sig", c, sig_w[c], 1);
      check("idle empty", c, empty_w[c], 1);
    end
  endtask

  initial begin
    int maxl [NCFG];
    int exp_lvl;
    logic [NCFG-1:0] low_seen;

    // Reset held with valid_in asserted: nothing is enqueued.
    reset = 1'b1; valid_in = 1'b1; data_in = 32'hDEADBEEF;
    repeat (3) @(posedge clock);
    @(negedge clock);
    for (int c = 0; c < NCFG; c++) begin
      check("reset sig", c, sig_w[c], 1);
      check("reset empty", c, empty_w[c], 1);
      check("reset full", c, full_w[c], 0);
      check("reset level", c, level_w[c], 0);
      check("reset busy", c, busy_w[c], 0);
      check("reset overflow", c, ovf_w[c], 0);
    end
    reset = 1'b0; valid_in = 1'b0;
    repeat (10) @(negedge clock);
    for (int c = 0; c < NCFG; c++) begin
      check("no frame after reset", c, sig_w[c], 1);
      check("empty after reset", c, empty_w[c], 1);
    end

    // Single words, the second one 10 idle cycles after the first drains.
    single_word(32'hAABBCCDD);
    repeat (10) @(posedge clock);
    single_word(32'h12345678);

    // Burst of six words; DEPTH=4 drops word 6.
    @(posedge clock); #1;
    data_in = 32'd1; valid_in = 1'b1; chained = 1'b0; drop_mask = '0;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clock); #1;
      if (i < 6) begin
        data_in   = 32'(i + 1);
        chained   = 1'b1;
        drop_mask = (i + 1 == 6) ? 6'b100000 : 6'b000000;
      end else begin
        valid_in  = 1'b0;
        drop_mask = '0;
      end
      @(negedge clock);
      for (int c = 0; c < NCFG; c++) begin
        exp_lvl = (i == 1) ? 1 : ((i - 1 < C_DEPTH[c]) ? i - 1 : C_DEPTH[c]);
        check("burst level", c, level_w[c], exp_lvl);
        check("burst full", c, full_w[c], (exp_lvl == C_DEPTH[c]) ? 1 : 0);
        check("burst overflow", c, ovf_w[c], (i == 6 && C_DEPTH[c] == 4) ? 1 : 0);
      end
    end
    chained = 1'b0;
    wait_idle(1500);

    // Paced streaming: 20 words, one per 200 cycles.
    for (int c = 0; c < NCFG; c++) maxl[c] = 0;
    for (int w = 0; w < 20; w++) begin
      @(posedge clock); #1;
      data_in  = {8'(w), 8'hC3 ^ 8'(w), 8'(w * 7), 8'hF0 - 8'(w)};
      valid_in = 1'b1;
      @(posedge clock); #1;
      valid_in = 1'b0;
      repeat (198) begin
        @(negedge clock);
        for (int c = 0; c < NCFG; c++)
          if (32'(level_w[c]) > maxl[c]) maxl[c] = 32'(level_w[c]);
      end
    end
    wait_idle(400);
    for (int c = 0; c < NCFG; c++) begin
      check("stream max level", c, maxl[c], 1);
      check("stream overflow", c, ovf_w[c], (C_DEPTH[c] == 4) ? 1 : 0);
    end
    check_q = 1'b1;
    repeat (2) @(negedge clock);

    // Reset in the middle of a data bit with a second word still queued.
    @(posedge clock); #1;
    data_in = 32'hCAFEF00D; valid_in = 1'b1; chained = 1'b0;
    @(posedge clock); #1;
    data_in = 32'h0BADBEEF; chained = 1'b1;
    @(posedge clock); #1;
    valid_in = 1'b0; chained = 1'b0;
    repeat (20) @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    for (int c = 0; c < NCFG; c++) begin
      check("pre-reset data bit", c, sig_w[c], 0);
      check("pre-reset level", c, level_w[c], 1);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    for (int c = 0; c < NCFG; c++) begin
      check("abort sig", c, sig_w[c], 1);
      check("abort busy", c, busy_w[c], 0);
      check("abort flush level", c, level_w[c], 0);
      check("abort flush empty", c, empty_w[c], 1);
      check("abort overflow clear", c, ovf_w[c], 0);
    end
    low_seen = '0;
    repeat (20) begin
      @(negedge clock);
      low_seen = low_seen | ~sig_w;
    end
    for (int c = 0; c < NCFG; c++) check("quiet after abort", c, low_seen[c], 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
